// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, word-length codes and the
// word-length / parity helpers used by the transmit (and future receive) path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic [1:0] WLS_5 = 2'b00;
   localparam logic [1:0] WLS_6 = 2'b01;
   localparam logic [1:0] WLS_7 = 2'b10;
   localparam logic [1:0] WLS_8 = 2'b11;

   function automatic logic [3:0] wordlen(input logic [1:0] wls);
      return 4'd5 + {2'b00, wls};
   endfunction

   // eps=1 gives even parity (XOR of active bits), eps=0 its inverse.
   function automatic logic parity_bit(input logic [7:0] data,
                                       input logic [1:0] wls,
                                       input logic       eps);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(wordlen(wls))) p = p ^ data[i];
      end
      return eps ? p : ~p;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts baud ticks 0..OVERSAMPLE-1 and flags the tick
// that closes a bit. Shared between the transmitter and the receiver.
module uart_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic BCLK,
   input  logic RST,
   input  logic tick,
   input  logic clear,
   output logic bit_end
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] cnt;

   // clear wins over tick, so a tick on the clearing edge is not counted.
   always_ff @(posedge BCLK or posedge RST) begin
      if (RST)            cnt <= '0;
      else if (clear)     cnt <= '0;
      else if (tick)      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
   end

   assign bit_end = tick & ~clear & (cnt == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 5-8 data bits LSB first, optional parity,
// 1 or 2 stop bits, with a break override on the line output.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_W     = 8
) (
   input  logic              BCLK,
   input  logic              RST,
   input  logic              baud_tick,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [1:0]        wls,
   input  logic              pen,
   input  logic              eps,
   input  logic              stb,
   input  logic              brk,
   output logic              txd,
   output logic              tsr_busy,
   output logic              tx_done,
   output tx_state_e         state_dbg
);

   // Handshake: a word transfers on any BCLK edge where tx_valid and tx_ready
   // are both high; tx_ready depends on the state register only.
   tx_state_e         state;
   logic [DATA_W-1:0] shift_q;
   logic [2:0]        bit_cnt;
   logic              stop_cnt;
   logic [1:0]        wls_q;
   logic              pen_q, stb_q, par_q;
   logic              txd_q, busy_q, done_q;
   logic              bit_end;
   logic [7:0]        data8;

   always_comb begin
      data8 = '0;
      for (int i = 0; i < DATA_W && i < 8; i++) data8[i] = tx_data[i];
   end

   uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
      .BCLK    (BCLK),
      .RST     (RST),
      .tick    (baud_tick),
      .clear   (state == IDLE),
      .bit_end (bit_end)
   );

   always_ff @(posedge BCLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         shift_q  <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         wls_q    <= WLS_8;
         pen_q    <= 1'b0;
         stb_q    <= 1'b0;
         par_q    <= 1'b0;
         txd_q    <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (tx_valid) begin
               // Parity is resolved at accept so later config changes cannot leak in.
               shift_q  <= tx_data;
               wls_q    <= wls;
               pen_q    <= pen;
               stb_q    <= stb;
               par_q    <= parity_bit(data8, wls, eps);
               bit_cnt  <= '0;
               stop_cnt <= 1'b0;
               txd_q    <= 1'b0;
               busy_q   <= 1'b1;
               state    <= START;
            end
            START: if (bit_end) begin
               txd_q   <= shift_q[0];
               shift_q <= shift_q >> 1;
               state   <= DATA;
            end
            DATA: if (bit_end) begin
               if ({1'b0, bit_cnt} == wordlen(wls_q) - 4'd1) begin
                  txd_q <= pen_q ? par_q : 1'b1;
                  state <= pen_q ? PARITY : STOP;
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  txd_q   <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
            end
            PARITY: if (bit_end) begin
               txd_q <= 1'b1;
               state <= STOP;
            end
            STOP: if (bit_end) begin
               if (stb_q && !stop_cnt) begin
                  stop_cnt <= 1'b1;
               end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign tx_ready  = (state == IDLE);
   assign txd       = txd_q & ~brk;
   assign tsr_busy  = busy_q;
   assign tx_done   = done_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: frame shapes, back-to-back, break,
// baud gating and asynchronous reset, checked against hand-built bit vectors.
module tb_uart_tx_framer;
   import uart_pkg::*;

   localparam int OS = 16;

   logic       BCLK = 1'b0;
   logic       RST = 1'b1;
   logic       baud_tick = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic [1:0] wls = 2'b11;
   logic       pen = 1'b0, eps = 1'b0, stb = 1'b0, brk = 1'b0;
   logic       tx_ready, txd, tsr_busy, tx_done;
   tx_state_e  state_dbg;

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt;

   uart_tx_framer #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
      .BCLK      (BCLK),
      .RST       (RST),
      .baud_tick (baud_tick),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .wls       (wls),
      .pen       (pen),
      .eps       (eps),
      .stb       (stb),
      .brk       (brk),
      .txd       (txd),
      .tsr_busy  (tsr_busy),
      .tx_done   (tx_done),
      .state_dbg (state_dbg)
   );

   // clock and watchdog
   always #5 BCLK = ~BCLK;

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called just before the accept edge. Samples every cycle on the falling
   // edge; bits[k] is frame bit k (start first), nb bits of OS cycles each.
   task automatic check_frame(input string tag, input logic [15:0] bits, input int nb,
                              input logic hold, input logic [7:0] nxt,
                              input logic scramble, input int brk_on);
      int last;
      last = OS * nb;
      check_eq({tag, " ready_pre"}, 16'(tx_ready), 16'd1);
      for (int j = 0; j <= last; j++) begin
         @(negedge BCLK);
         if (j == 0) begin
            tx_valid = hold;
            tx_data  = nxt;
            if (scramble) begin
               wls = 2'b11; pen = ~pen; eps = ~eps; stb = ~stb;
            end
         end
         if (j == brk_on) brk = 1'b1;
         #1;
         if (j < last) begin
            check_eq({tag, " txd"}, 16'(txd), 16'(brk ? 1'b0 : bits[j / OS]));
            check_eq({tag, " busy"}, 16'(tsr_busy), 16'd1);
            check_eq({tag, " ready"}, 16'(tx_ready), 16'd0);
            check_eq({tag, " done"}, 16'(tx_done), 16'd0);
            if (j < OS) check_eq({tag, " state_start"}, 16'(state_dbg), 16'(START));
         end else begin
            check_eq({tag, " txd_end"}, 16'(txd), 16'(brk ? 1'b0 : 1'b1));
            check_eq({tag, " busy_end"}, 16'(tsr_busy), 16'd0);
            check_eq({tag, " ready_end"}, 16'(tx_ready), 16'd1);
            check_eq({tag, " done_end"}, 16'(tx_done), 16'd1);
            check_eq({tag, " state_end"}, 16'(state_dbg), 16'(IDLE));
         end
      end
   endtask

   initial begin
      // reset
      repeat (3) @(negedge BCLK);
      #1;
      check_eq("rst txd", 16'(txd), 16'd1);
      check_eq("rst ready", 16'(tx_ready), 16'd1);
      check_eq("rst busy", 16'(tsr_busy), 16'd0);
      check_eq("rst done", 16'(tx_done), 16'd0);
      check_eq("rst state", 16'(state_dbg), 16'(IDLE));
      @(negedge BCLK);
      RST = 1'b0;
      repeat (2) @(negedge BCLK);

      // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
      wls = 2'b11; pen = 1'b0; stb = 1'b0; tx_data = 8'h55; tx_valid = 1'b1;
      check_frame("8n1_55", 16'b10_1010_1010, 10, 1'b0, 8'h00, 1'b0, -1);
      repeat (3) @(negedge BCLK);

      // 7E1 0x41: 0, 1,0,0,0,0,0,1, par 0, 1
      wls = 2'b10; pen = 1'b1; eps = 1'b1; stb = 1'b0; tx_data = 8'h41; tx_valid = 1'b1;
      check_frame("7e1_41", 16'b10_1000_0010, 10, 1'b0, 8'h00, 1'b0, -1);
      repeat (3) @(negedge BCLK);

      // 5O2 0xFF with config scrambled mid-frame: 0, 1,1,1,1,1, par 0, 1, 1
      wls = 2'b00; pen = 1'b1; eps = 1'b0; stb = 1'b1; tx_data = 8'hFF; tx_valid = 1'b1;
      check_frame("5o2_ff", 16'b1_1011_1110, 9, 1'b0, 8'h00, 1'b1, -1);
      repeat (3) @(negedge BCLK);

      // back-to-back 8N1 0xA5 then 0x3C
      wls = 2'b11; pen = 1'b0; eps = 1'b0; stb = 1'b0; tx_data = 8'hA5; tx_valid = 1'b1;
      check_frame("b2b_a5", 16'b11_0100_1010, 10, 1'b1, 8'h3C, 1'b0, -1);
      check_frame("b2b_3c", 16'b10_0111_1000, 10, 1'b0, 8'h00, 1'b0, -1);
      @(negedge BCLK);
      #1;
      check_eq("b2b idle txd", 16'(txd), 16'd1);
      check_eq("b2b idle ready", 16'(tx_ready), 16'd1);
      repeat (3) @(negedge BCLK);

      // break during DATA of 0xFF, released in IDLE
      tx_data = 8'hFF; tx_valid = 1'b1;
      check_frame("brk_ff", 16'b11_1111_1110, 10, 1'b0, 8'h00, 1'b0, 40);
      @(negedge BCLK);
      brk = 1'b0;
      #1;
      check_eq("brk release txd", 16'(txd), 16'd1);
      check_eq("brk release ready", 16'(tx_ready), 16'd1);
      repeat (3) @(negedge BCLK);

      // baud gating: FSM holds without ticks, tick on accept edge not counted
      baud_tick = 1'b0; tx_data = 8'h55; tx_valid = 1'b1;
      @(posedge BCLK);
      #1 tx_valid = 1'b0;
      repeat (20) @(negedge BCLK);
      #1;
      check_eq("hold state", 16'(state_dbg), 16'(START));
      check_eq("hold txd", 16'(txd), 16'd0);
      baud_tick = 1'b1;
      repeat (15) @(negedge BCLK);
      #1;
      check_eq("tick15 state", 16'(state_dbg), 16'(START));
      @(negedge BCLK);
      #1;
      check_eq("tick16 state", 16'(state_dbg), 16'(DATA));
      check_eq("tick16 txd", 16'(txd), 16'd1);
      RST = 1'b1;
      #1;
      check_eq("abort state", 16'(state_dbg), 16'(IDLE));
      @(negedge BCLK);
      RST = 1'b0;
      repeat (2) @(negedge BCLK);

      // async reset in the middle of data bit 3 of 0x00
      wls = 2'b11; pen = 1'b0; stb = 1'b0; tx_data = 8'h00; tx_valid = 1'b1;
      @(posedge BCLK);
      #1 tx_valid = 1'b0;
      repeat (70) @(posedge BCLK);
      #1;
      check_eq("pre_rst txd", 16'(txd), 16'd0);
      check_eq("pre_rst state", 16'(state_dbg), 16'(DATA));
      #2 RST = 1'b1;
      #1;
      check_eq("async_rst txd", 16'(txd), 16'd1);
      check_eq("async_rst busy", 16'(tsr_busy), 16'd0);
      check_eq("async_rst ready", 16'(tx_ready), 16'd1);
      check_eq("async_rst state", 16'(state_dbg), 16'(IDLE));
      done_cnt = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge BCLK);
         if (i == 5) RST = 1'b0;
         if (tx_done) done_cnt++;
      end
      check_eq("async_rst no_done", 16'(done_cnt), 16'd0);

      // clean 8E2 frame after reset, 0x0F: 0, 1,1,1,1,0,0,0,0, par 0, 1, 1
      wls = 2'b11; pen = 1'b1; eps = 1'b1; stb = 1'b1; tx_data = 8'h0F; tx_valid = 1'b1;
      check_frame("8e2_0f", 16'b1100_0001_1110, 12, 1'b0, 8'h00, 1'b0, -1);
      repeat (3) @(negedge BCLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Parametrised UART transmit engine. It replaces the fixed load/shift timing controller with a complete framer: start bit, 5–8 data bits, optional parity, 1 or 2 stop bits, and a break. It sits between the TX holding register/FIFO (valid/ready handshake) and the TXD pin. Bit timing comes from a baud_tick enable at OVERSAMPLE× the bit rate.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period (legal range 4–64).
DATA_W, 8, maximum data width; tx_data width. Word length is selected at run time by wls.

Ports:
BCLK  in  1  system clock; all logic on rising edge.
RST  in  1  reset, asynchronous, active-high.
baud_tick  in  1  one-BCLK enable pulse at OVERSAMPLE× the bit rate.
tx_data  in  DATA_W  byte to send, LSB transmitted first.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  framer can accept a word; high only in IDLE.
wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
pen  in  1  parity enable.
eps  in  1  1 = even parity, 0 = odd parity.
stb  in  1  0 = one stop bit, 1 = two stop bits.
brk  in  1  break: force TXD low.
txd  out  1  serial line, registered, idles high.
tsr_busy  out  1  high from accept through the end of the last stop bit.
tx_done  out  1  one-BCLK pulse when a frame completes.

Behaviour:
- Reset values: txd=1, tsr_busy=0, tx_ready=1, tx_done=0, state=IDLE, counters=0.
- RST is asynchronous. Asserting it mid-frame returns txd to 1 immediately and abandons the frame with no tx_done.
- States: IDLE, START, DATA, PARITY, STOP.
- tx_ready equals (state==IDLE), decoded from the state register only. There is no combinational path from any input to tx_ready.
- Accept: tx_valid & tx_ready on a BCLK edge. On that edge:
  - latch tx_data, wls, pen, eps and stb into shadow registers;
  - go to START, set tsr_busy=1, set txd=0, clear the tick counter and bit counter.
- Config inputs that change mid-frame have no effect until the next accept.
- Bit period: the tick counter increments on each baud_tick. A bit ends on the baud_tick where counter==OVERSAMPLE-1; the counter then wraps to 0. Each bit lasts exactly OVERSAMPLE baud_ticks. Without baud_tick the FSM holds.
- START → DATA at the end of its bit. txd = shadow bit 0.
- DATA shifts LSB-first. The bit counter counts to wordlen-1 (wordlen = 5 + wls). On the last data bit:
  - go to PARITY if pen, else to STOP.
- PARITY sends one bit:
  - even: XOR of the active data bits;
  - odd: its inverse.
  - Bits above wordlen never contribute.
- STOP sends txd=1 for 1 bit period (stb=0) or 2 bit periods (stb=1).
- End of the last stop bit, on the same edge:
  - go to IDLE, tsr_busy=0, tx_done=1 for that one cycle.
  - tx_ready rises in the following cycle.
  - Back-to-back frames therefore have zero idle bits beyond the stop bits.
- txd is registered: it updates on the edge that enters each bit.
- brk: while asserted, txd output is 0 regardless of state (final AND stage). The FSM and counters continue unaffected.
  - A frame already in progress still completes and pulses tx_done.
  - An accept is still allowed during break.
- tx_valid while not ready is ignored. The upstream holds the data; there is no loss.
- baud_tick on the same edge as accept does not count toward the start bit.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (IDLE=3'd0 … STOP=3'd4);
  - wls codes and a wordlen function (5 + wls);
  - parity helper function(data, wls, eps).
- One natural sub-module: uart_bit_timer. It contains the OVERSAMPLE tick counter with a clear input and emits a bit_end pulse. The same sub-module is reused by the future receiver.

Test Plan:
- 8N1, OVERSAMPLE=16, baud_tick every cycle, tx_data=0x55:
  - txd sequence 0,1,0,1,0,1,0,1,0,1 then 1, each held 16 cycles;
  - tx_done 160 cycles after accept; tsr_busy high throughout.
- 7E1, tx_data=0x41: data bits 1,0,0,0,0,0,1, parity bit 0 (two ones, even), one stop bit; frame is 10 bits long.
- 5O2, tx_data=0xFF: only 1,1,1,1,1 sent, parity 0 (five ones, odd), two stop bits; frame is 9 bits.
  - Changing wls to 11 mid-frame does not alter the frame.
- Back-to-back: tx_valid held high with 0xA5 then 0x3C. The second start bit begins exactly one BCLK after the first tx_done, and tx_ready is low during both frames.
- RST asserted in the middle of data bit 3 (asynchronous, not aligned to BCLK):
  - txd=1 and tsr_busy=0 immediately; no tx_done;
  - a next accept after release produces a full clean frame.
- brk asserted during DATA of 0xFF: txd=0 while brk is high. tx_done still arrives at the nominal cycle, and txd=1 after brk is released in IDLE.
